// File: rtl/sonata_input_debounce.sv
// sonata_input_debounce: synchronise, polarity-correct and debounce raw pad inputs, with edge pulses, sticky events and a masked IRQ
module sonata_input_debounce #(
  parameter int               Width       = 16,
  parameter logic             ActiveLow   = 1'b1,
  parameter int               TickCycles  = 30000,
  parameter int               StableTicks = 10,
  parameter logic [Width-1:0] ResetState  = '0
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic [Width-1:0] pins_i,
  output logic [Width-1:0] state_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic [Width-1:0] event_o,
  input  logic [Width-1:0] event_clr_i,
  input  logic [Width-1:0] irq_en_i,
  output logic             irq_o
);
  localparam int               PW      = (TickCycles > 2) ? $clog2(TickCycles) : 1;
  localparam int               CW      = $clog2(StableTicks + 1);
  localparam logic [Width-1:0] Inv     = {Width{ActiveLow}};
  localparam logic [PW-1:0]    TickMax = PW'(TickCycles - 1);
  localparam logic [CW-1:0]    CntMax  = CW'(StableTicks - 1);
  logic [Width-1:0] r_sync1, r_sync2, r_state, r_rise, r_fall, r_event;
  logic             r_irq;
  logic [PW-1:0]    r_presc;
  logic [CW-1:0]    r_cnt     [Width];
  logic [CW-1:0]    w_cnt_nxt [Width];
  logic [Width-1:0] w_s, w_diff, w_accept;
  logic             w_tick;
  assign w_s    = r_sync2 ^ Inv;
  assign w_diff = w_s ^ r_state;
  assign w_tick = r_presc == TickMax;
  assign state_o = r_state;
  assign rise_o  = r_rise;
  assign fall_o  = r_fall;
  assign event_o = r_event;
  assign irq_o   = r_irq;
  // two-flop synchroniser; reset value decodes to ResetState so reset exit never looks like an edge
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_sync1 <= ResetState ^ Inv;
      r_sync2 <= ResetState ^ Inv;
    end else begin
      r_sync1 <= pins_i;
      r_sync2 <= r_sync1;
    end
  end
  // free-running prescaler shared by every bit
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) r_presc <= '0;
    else             r_presc <= w_tick ? '0 : r_presc + 1'b1;
  end
  // hold counters: any agreement clears progress, each tick of disagreement advances, last tick accepts
  always_comb begin
    w_accept  = '0;
    w_cnt_nxt = '{default: '0};
    for (int i = 0; i < Width; i++) begin
      w_accept[i]  = w_diff[i] & w_tick & (r_cnt[i] == CntMax);
      w_cnt_nxt[i] = (!w_diff[i] || w_accept[i]) ? '0 : w_tick ? r_cnt[i] + 1'b1 : r_cnt[i];
    end
  end
  // hold counter registers
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      for (int i = 0; i < Width; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < Width; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end
  // accepted level and its edge pulses update together
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_state <= ResetState;
      r_rise  <= '0;
      r_fall  <= '0;
    end else begin
      r_state <= r_state ^ w_accept;
      r_rise  <= w_accept & w_s;
      r_fall  <= w_accept & ~w_s;
    end
  end
  // sticky events (a new edge beats a same-cycle clear) and registered masked interrupt
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_event <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_event <= (r_event & ~event_clr_i) | r_rise | r_fall;
      r_irq   <= |(r_event & irq_en_i);
    end
  end
endmodule

// File: tb/tb_sonata_input_debounce.sv
// tb_sonata_input_debounce: scoreboard bench with a tick-counting reference model for sonata_input_debounce
module tb_sonata_input_debounce;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] pins = 4'hF, clr = 4'h0, en = 4'h0;
  logic [3:0] state_o, rise_o, fall_o, event_o;
  logic       irq_o;
  int checks = 0, failures = 0;
  int rise_cnt [4];
  typedef struct packed {logic [3:0] st, ri, fa, ev; logic irq;} exp_t;
  exp_t q[$];
  sonata_input_debounce #(
    .Width(4), .ActiveLow(1'b1), .TickCycles(4), .StableTicks(3), .ResetState(4'h0)
  ) dut (
    .clk_sys_i(clk), .rst_sys_ni(rst_n), .pins_i(pins), .state_o(state_o),
    .rise_o(rise_o), .fall_o(fall_o), .event_o(event_o), .event_clr_i(clr),
    .irq_en_i(en), .irq_o(irq_o)
  );
  always #5 clk = ~clk;
  // reference model: cycles since reset define ticks; a level is taken after 3 ticks of continuous disagreement
  int         ncyc;
  int         tk [4];
  logic [3:0] h1, h2, ms, mr, mf, me;
  logic       mi;
  always @(posedge clk) begin
    logic [3:0] s, ns, nr, nf, ne;
    logic       ni, tick;
    if (!rst_n) begin
      ncyc = 0; h1 = 4'hF; h2 = 4'hF;
      ms = 0; mr = 0; mf = 0; me = 0; mi = 0;
      for (int b = 0; b < 4; b++) tk[b] = 0;
    end else begin
      s = ~h2;
      tick = (ncyc % 4) == 3;
      ni = |(me & en);
      ne = (me & ~clr) | mr | mf;
      ns = ms; nr = 0; nf = 0;
      for (int b = 0; b < 4; b++) begin
        if (s[b] != ms[b]) begin
          if (tick) tk[b]++;
          if (tk[b] == 3) begin
            ns[b] = s[b]; nr[b] = s[b]; nf[b] = !s[b]; tk[b] = 0;
          end
        end else tk[b] = 0;
      end
      h2 = h1; h1 = pins; ncyc++;
      ms = ns; mr = nr; mf = nf; me = ne; mi = ni;
    end
    q.push_back('{ms, mr, mf, me, mi});
  end
  // monitor: every cycle the DUT presents a full output vector, compared against the oldest expectation
  always @(posedge clk) begin
    exp_t e;
    #2;
    for (int b = 0; b < 4; b++) if (rise_o[b]) rise_cnt[b]++;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks += 5;
      if (state_o !== e.st) begin failures++; $display("FAIL state_o got=%h exp=%h t=%0t", state_o, e.st, $time); end
      if (rise_o !== e.ri) begin failures++; $display("FAIL rise_o got=%h exp=%h t=%0t", rise_o, e.ri, $time); end
      if (fall_o !== e.fa) begin failures++; $display("FAIL fall_o got=%h exp=%h t=%0t", fall_o, e.fa, $time); end
      if (event_o !== e.ev) begin failures++; $display("FAIL event_o got=%h exp=%h t=%0t", event_o, e.ev, $time); end
      if (irq_o !== e.irq) begin failures++; $display("FAIL irq_o got=%b exp=%b t=%0t", irq_o, e.irq, $time); end
    end
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin failures++; $display("FAIL %s got=%0d exp=%0d", name, got, exp); end
  endtask
  task automatic chk_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin failures++; $display("FAIL %s got=%0d exp=%0d..%0d", name, got, lo, hi); end
  endtask
  // cycles until state_o[b] reaches v, -1 if it never does within the bound
  task automatic wait_state(input int b, input logic v, output int d);
    d = -1;
    for (int k = 1; k <= 30; k++) begin
      step(1);
      if (state_o[b] == v) begin d = k; break; end
    end
  endtask
  initial begin
    int d, r0, r1, found;
    for (int b = 0; b < 4; b++) rise_cnt[b] = 0;
    step(3);
    rst_n = 1'b1;
    r0 = rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3];
    step(100);
    chk("t1_state", int'(state_o), 0);
    chk("t1_irq", int'(irq_o), 0);
    chk("t1_no_rise", rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3], r0);
    r0 = rise_cnt[0];
    pins[0] = 1'b0;
    wait_state(0, 1'b1, d);
    chk_range("t2_delay", d, 11, 15);
    step(5);
    chk("t2_rise_pulses", rise_cnt[0] - r0, 1);
    chk("t2_event", int'(event_o[0]), 1);
    r1 = rise_cnt[1];
    pins[1] = 1'b0;
    step(6);
    pins[1] = 1'b1;
    step(20);
    chk("t3_state", int'(state_o[1]), 0);
    chk("t3_no_rise", rise_cnt[1] - r1, 0);
    en = 4'h1;
    step(1);
    chk("t4_irq_set", int'(irq_o), 1);
    clr = 4'h1;
    step(1);
    clr = 4'h0;
    chk("t4_event_clr", int'(event_o[0]), 0);
    step(1);
    chk("t4_irq_clr", int'(irq_o), 0);
    en = 4'h0;
    pins[0] = 1'b1;
    wait_state(0, 1'b0, d);
    chk_range("t4_fall_delay", d, 11, 15);
    step(3);
    chk("t4_event_again", int'(event_o[0]), 1);
    chk("t4_irq_masked", int'(irq_o), 0);
    pins[2] = 1'b0;
    step(20);
    clr = 4'h4;
    step(1);
    clr = 4'h0;
    chk("t5_pre_clear", int'(event_o[2]), 0);
    pins[2] = 1'b1;
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      step(1);
      if (fall_o[2]) begin
        found = 1;
        clr = 4'h4;
        step(1);
        clr = 4'h0;
      end
    end
    chk("t5_fall_seen", found, 1);
    chk("t5_set_wins", int'(event_o[2]), 1);
    pins[3] = 1'b0;
    step(10);
    rst_n = 1'b0;
    #1;
    chk("t6_async_state", int'(state_o), 0);
    chk("t6_async_rise", int'(rise_o), 0);
    step(2);
    rst_n = 1'b1;
    wait_state(3, 1'b1, d);
    chk_range("t6_redebounce", d, 11, 15);
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        step($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 2) == 0) pins = 4'($urandom_range(0, 15));
      en = 4'($urandom_range(0, 15));
      clr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      step(1);
      clr = 4'h0;
      step($urandom_range(0, 14));
    end
    step(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
